ibm_t: RTL and testbench

IBM_T -- requirements
Module: ibm_t

---
 rtl/ibm_t_if.sv | 38 +++
 rtl/ibm_t.sv | 215 +++++++++++++++++++++
 tb/tb_ibm_t.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ibm_t_if.sv
// ---------------------------------------------------------------------------
// ibm_t_if -- request/result bundle for the inversionless Berlekamp-Massey
// solver ibm_t.
//   i_code  [1:0]       field select (00 GF(2^6), 01 GF(2^8), 10 GF(2^10))
//   i_start             request to solve one syndrome set
//   i_synd  [2T*M-1:0]  syndromes S1..S2T, S1 in the LSBs
//   o_ready             solver can take i_start
//   o_valid             one-cycle result strobe
//   o_sigma [(T+1)*M-1:0] locator coefficients sigma0..sigmaT, sigma0 in LSBs
//   o_deg               tracked locator length L
//   o_fail              final locator degree differs from L
// Modports: master drives requests, slave is the solver.
// ---------------------------------------------------------------------------
interface ibm_t_if #(
   parameter int M = 10,
   parameter int T = 4
);
   localparam int DW = $clog2(T + 1);

   logic [1:0]           i_code;
   logic                 i_start;
   logic [2*T*M-1:0]     i_synd;
   logic                 o_ready;
   logic                 o_valid;
   logic [(T+1)*M-1:0]   o_sigma;
   logic [DW-1:0]        o_deg;
   logic                 o_fail;

   modport master (
      output i_code, i_start, i_synd,
      input  o_ready, o_valid, o_sigma, o_deg, o_fail
   );

   modport slave (
      input  i_code, i_start, i_synd,
      output o_ready, o_valid, o_sigma, o_deg, o_fail
   );
endinterface

// File: rtl/ibm_t.sv
// ---------------------------------------------------------------------------
// ibm_t -- inversionless Berlekamp-Massey key-equation solver, one iteration
// per clock, T iterations per syndrome set, selectable GF(2^6/8/10).
// Ports:
//   i_clk   rising-edge clock
//   i_rst   synchronous active-high reset
//   bus     ibm_t_if.slave (code/start/syndromes in, ready/valid/results out)
// Optional feature: define IBM_ZERO_SKIP_EN to let an all-zero syndrome set
// skip the iterations and report sigma=1, L=0 one cycle after accept.
// ---------------------------------------------------------------------------
module ibm_t #(
   parameter int M = 10,
   parameter int T = 4
) (
   input  logic    i_clk,
   input  logic    i_rst,
   ibm_t_if.slave  bus
);
   localparam int LW = $clog2(2*T + 1);      // L can reach 2T-1
   localparam int KW = $clog2(2*T + 2) + 1;  // k spans -T-1..T
   localparam int RW = $clog2(T + 1);
   localparam int DW = $clog2(T + 1);
   localparam int SW = (T + 1) * M;

   typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

   state_t                state, state_nx;
   logic [M-1:0]          synd  [2*T];   // synd[0] holds S1
   logic [M-1:0]          sigma [T+1];
   logic [M-1:0]          bpoly [T+1];
   logic [M-1:0]          gamma;
   logic signed [KW-1:0]  k;
   logic [LW-1:0]         len;
   logic [RW-1:0]         r;
   logic [1:0]            code;

   logic [SW-1:0]         sig_out;
   logic [DW-1:0]         deg_out;
   logic                  fail_out;

   logic                  ready, accept, last, skip, upd, fail_nx;
   logic [M-1:0]          delta, gamma_nx;
   logic [M-1:0]          sigma_nx [T+1];
   logic [M-1:0]          bpoly_nx [T+1];
   logic signed [KW-1:0]  k_nx;
   logic [LW-1:0]         len_nx;

   // Reduction polynomial including the x^m term.
   function automatic logic [M:0] fpoly(input logic [1:0] c);
      case (c)
         2'b00:   return (M+1)'(11'h043);
         2'b01:   return (M+1)'(11'h11D);
         default: return (M+1)'(11'h409);
      endcase
   endfunction

   function automatic logic [M:0] ftop(input logic [1:0] c);
      case (c)
         2'b00:   return (M+1)'(11'h040);
         2'b01:   return (M+1)'(11'h100);
         default: return (M+1)'(11'h400);
      endcase
   endfunction

   function automatic logic [M-1:0] fmask(input logic [1:0] c);
      case (c)
         2'b00:   return M'(10'h03F);
         2'b01:   return M'(10'h0FF);
         default: return M'(10'h3FF);
      endcase
   endfunction

   // MSB-first shift-and-add multiply; operands are masked so bits above m
   // never leak in and the result stays below 2^m.
   function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a,
                                           input logic [M-1:0] b,
                                           input logic [1:0]   c);
      logic [M:0]   acc;
      logic [M-1:0] am, bm;
      am  = a & fmask(c);
      bm  = b & fmask(c);
      acc = '0;
      for (int i = M - 1; i >= 0; i--) begin
         acc = {acc[M-1:0], 1'b0};
         if ((acc & ftop(c)) != '0) acc = acc ^ fpoly(c);
         if (bm[i]) acc = acc ^ {1'b0, am};
      end
      return acc[M-1:0];
   endfunction

   assign ready  = (state == S_IDLE) || (state == S_DONE);
   assign accept = ready && bus.i_start && (bus.i_code != 2'b11);
   assign last   = (r == RW'(T - 1));

`ifdef IBM_ZERO_SKIP_EN
   logic synd_zero;
   always_comb begin
      synd_zero = 1'b1;
      for (int i = 0; i < 2*T; i++)
         if ((bus.i_synd[i*M +: M] & fmask(bus.i_code)) != '0) synd_zero = 1'b0;
   end
   assign skip = synd_zero;
`else
   assign skip = 1'b0;
`endif

   // Discrepancy and polynomial update for the current iteration r.
   always_comb begin
      logic [M-1:0] s_sel;
      int           hi;
      delta = '0;
      for (int j = 0; j <= T; j++) begin
         s_sel = '0;
         // S_(2r+1-j) lives at synd[2r-j]; out-of-range terms select zero
         for (int i = 0; i < 2*T; i++)
            if (i + j == 2 * int'(r)) s_sel = synd[i];
         delta = delta ^ gf_mul(sigma[j], s_sel, code);
      end

      upd = (delta != '0) && (k >= 0);

      sigma_nx[0] = gf_mul(gamma, sigma[0], code);
      for (int j = 1; j <= T; j++)
         sigma_nx[j] = gf_mul(gamma, sigma[j], code) ^ gf_mul(delta, bpoly[j-1], code);

      bpoly_nx[0] = '0;
      gamma_nx    = gamma;
      k_nx        = k + KW'(1);
      len_nx      = len;
      if (upd) begin
         for (int j = 1; j <= T; j++) bpoly_nx[j] = sigma[j-1];
         gamma_nx = delta;
         k_nx     = ~k;                          // -k-1
         len_nx   = LW'({r, 1'b1}) - len;        // 2r+1-L
      end else begin
         for (int j = 1; j <= T; j++) bpoly_nx[j] = (j >= 2) ? bpoly[(j >= 2) ? j-2 : 0] : '0;
      end

      hi = -1;
      for (int j = 0; j <= T; j++)
         if (sigma_nx[j] != '0) hi = j;
      fail_nx = (hi != int'(len_nx));
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) state <= S_IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (accept) state_nx = skip ? S_DONE : S_ITER;
         S_ITER:  if (last)   state_nx = S_DONE;
         S_DONE:  state_nx = accept ? (skip ? S_DONE : S_ITER) : S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < 2*T; i++) synd[i] <= '0;
         for (int j = 0; j <= T; j++) begin
            sigma[j] <= '0;
            bpoly[j] <= '0;
         end
         gamma    <= '0;
         k        <= '0;
         len      <= '0;
         r        <= '0;
         code     <= '0;
         sig_out  <= '0;
         deg_out  <= '0;
         fail_out <= 1'b0;
      end else if (accept) begin
         for (int i = 0; i < 2*T; i++) synd[i] <= bus.i_synd[i*M +: M];
         for (int j = 0; j <= T; j++) begin
            sigma[j] <= (j == 0) ? M'(1) : '0;
            bpoly[j] <= (j == 0) ? M'(1) : '0;
         end
         gamma <= M'(1);
         k     <= '0;
         len   <= '0;
         r     <= '0;
         code  <= bus.i_code;
         if (skip) begin
            sig_out  <= SW'(1);
            deg_out  <= '0;
            fail_out <= 1'b0;
         end
      end else if (state == S_ITER) begin
         for (int j = 0; j <= T; j++) begin
            sigma[j] <= sigma_nx[j];
            bpoly[j] <= bpoly_nx[j];
         end
         gamma <= gamma_nx;
         k     <= k_nx;
         len   <= len_nx;
         r     <= r + RW'(1);
         // Results are captured on the edge entering DONE and held after.
         if (last) begin
            for (int j = 0; j <= T; j++) sig_out[j*M +: M] <= sigma_nx[j];
            deg_out  <= DW'(len_nx);
            fail_out <= fail_nx;
         end
      end
   end

   assign bus.o_ready = ready;
   assign bus.o_valid = (state == S_DONE);
   assign bus.o_sigma = sig_out;
   assign bus.o_deg   = deg_out;
   assign bus.o_fail  = fail_out;

endmodule

// File: tb/tb_ibm_t.sv
// ---------------------------------------------------------------------------
// tb_ibm_t -- self-checking bench for ibm_t (M=10, T=4). A table-based GF
// model solves each accepted syndrome set; a negedge scoreboard matches every
// o_valid against the queued expectation, including its cycle of arrival.
// ---------------------------------------------------------------------------
module tb_ibm_t;
   localparam int M  = 10;
   localparam int T  = 4;
   localparam int NS = 2 * T;
   localparam int SW = (T + 1) * M;

   typedef struct {
      logic [SW-1:0] sig;
      int            deg;
      bit            fl;
      int            due;
   } exp_t;

   logic i_clk = 1'b0;
   logic i_rst = 1'b1;

   ibm_t_if #(.M(M), .T(T)) bus();
   ibm_t #(.M(M), .T(T)) dut (.i_clk(i_clk), .i_rst(i_rst), .bus(bus));

   always #5 i_clk = ~i_clk;

   int   n_chk  = 0;
   int   n_fail = 0;
   int   cyc    = 0;
   exp_t exp_q[$];
   int   sv[NS];
   int   gexp[3][1024];
   int   glog[3][1024];

   always @(posedge i_clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   function automatic int fm(input int c);
      return (c == 0) ? 6 : (c == 1) ? 8 : 10;
   endfunction

   function automatic int fn(input int c);
      return (1 << fm(c)) - 1;
   endfunction

   task automatic build_tables();
      int poly[3] = '{32'h43, 32'h11D, 32'h409};
      for (int c = 0; c < 3; c++) begin
         int v;
         v = 1;
         for (int i = 0; i < fn(c); i++) begin
            gexp[c][i] = v;
            glog[c][v] = i;
            v = v << 1;
            if ((v >> fm(c)) != 0) v = v ^ poly[c];
         end
      end
   endtask

   function automatic int gmul(input int c, input int a, input int b);
      if (a == 0 || b == 0) return 0;
      return gexp[c][(glog[c][a] + glog[c][b]) % fn(c)];
   endfunction

   function automatic int gpow(input int c, input int e);
      return gexp[c][e % fn(c)];
   endfunction

   // Plain-integer Berlekamp-Massey on the current sv[] for field c.
   function automatic exp_t model(input int c);
      int   sg[T+1], bb[T+1], ns[T+1], nb[T+1], s[NS];
      int   gam, kk, d, L, hi, idx, msk;
      exp_t e;
      msk = (1 << fm(c)) - 1;
      for (int i = 0; i < NS; i++) s[i] = sv[i] & msk;
      for (int j = 0; j <= T; j++) begin
         sg[j] = (j == 0) ? 1 : 0;
         bb[j] = (j == 0) ? 1 : 0;
      end
      gam = 1; kk = 0; L = 0;
      for (int r = 0; r < T; r++) begin
         d = 0;
         for (int j = 0; j <= T; j++) begin
            idx = 2*r + 1 - j;
            if (idx >= 1 && idx <= NS) d = d ^ gmul(c, sg[j], s[idx-1]);
         end
         for (int j = 0; j <= T; j++) begin
            ns[j] = gmul(c, gam, sg[j]);
            if (j > 0) ns[j] = ns[j] ^ gmul(c, d, bb[j-1]);
         end
         if (d != 0 && kk >= 0) begin
            for (int j = 0; j <= T; j++) nb[j] = (j == 0) ? 0 : sg[(j == 0) ? 0 : j-1];
            gam = d;
            kk  = -kk - 1;
            L   = 2*r + 1 - L;
         end else begin
            for (int j = 0; j <= T; j++) nb[j] = (j < 2) ? 0 : bb[(j < 2) ? 0 : j-2];
            kk = kk + 1;
         end
         sg = ns;
         bb = nb;
      end
      hi = -1;
      for (int j = 0; j <= T; j++) if (sg[j] != 0) hi = j;
      e.sig = '0;
      for (int j = 0; j <= T; j++) e.sig[j*M +: M] = sg[j][M-1:0];
      e.deg = L;
      e.fl  = (hi != L);
      e.due = 0;
      return e;
   endfunction

   // Drives one request; btb=1 launches it on the o_valid cycle of the
   // previous one. exp_acc=1 queues the model result.
   task automatic send(input int c, input bit btb, input bit exp_acc);
      exp_t e;
      int   n;
      bit   allz;
      n = 0;
      if (btb) while (!bus.o_valid && n < 40) begin @(posedge i_clk); #1; n++; end
      else     while (!bus.o_ready && n < 40) begin @(posedge i_clk); #1; n++; end
      if (n >= 40) chk(btb ? "wait_valid" : "wait_ready", btb ? bus.o_valid : bus.o_ready, 1);
      bus.i_code = 2'(c);
      for (int i = 0; i < NS; i++) bus.i_synd[i*M +: M] = sv[i][M-1:0];
      bus.i_start = 1'b1;
      if (exp_acc) chk("ready_at_start", bus.o_ready, 1);
      @(posedge i_clk); #1;
      bus.i_start = 1'b0;
      if (exp_acc) begin
         e = model(c);
         e.due = cyc + T;
         allz = 1'b1;
         for (int i = 0; i < NS; i++) if ((sv[i] & fn(c)) != 0) allz = 1'b0;
`ifdef IBM_ZERO_SKIP_EN
         if (allz) e.due = cyc;
`endif
         if (allz) chk("zero_model_sigma", e.sig, 1);
         exp_q.push_back(e);
      end
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (exp_q.size() > 0 && n < 60) begin @(posedge i_clk); #1; n++; end
      if (exp_q.size() > 0) begin
         chk("drain", exp_q.size(), 0);
         exp_q.delete();
      end
      @(posedge i_clk); #1;
   endtask

   task automatic gen_err(input int c, input int ne);
      int pos[4], mag[4];
      bit dup;
      for (int e = 0; e < ne; e++) begin
         do begin
            pos[e] = $urandom_range(fn(c) - 1, 0);
            dup = 1'b0;
            for (int q = 0; q < e; q++) if (pos[q] == pos[e]) dup = 1'b1;
         end while (dup);
         mag[e] = $urandom_range(fn(c), 1);
      end
      for (int j = 1; j <= NS; j++) begin
         sv[j-1] = 0;
         for (int e = 0; e < ne; e++) sv[j-1] = sv[j-1] ^ gmul(c, mag[e], gpow(c, pos[e] * j));
      end
   endtask

   // Scoreboard: every o_valid must match the oldest expectation, on time.
   always @(negedge i_clk) begin
      exp_t e;
      if (!i_rst) begin
         if (bus.o_valid) begin
            if (exp_q.size() == 0) chk("spurious_valid", bus.o_valid, 0);
            else begin
               e = exp_q.pop_front();
               chk("valid_cycle", cyc, e.due);
               chk("sigma", bus.o_sigma, e.sig);
               chk("deg", bus.o_deg, e.deg);
               chk("fail", bus.o_fail, e.fl);
            end
         end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            chk("valid_missing", bus.o_valid, 1);
            void'(exp_q.pop_front());
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.i_start = 1'b0;
      bus.i_code  = 2'b00;
      bus.i_synd  = '0;
      build_tables();

      // Reset state
      repeat (2) @(posedge i_clk);
      #1;
      chk("rst_ready", bus.o_ready, 1);
      chk("rst_valid", bus.o_valid, 0);
      chk("rst_sigma", bus.o_sigma, 0);
      chk("rst_deg",   bus.o_deg, 0);
      chk("rst_fail",  bus.o_fail, 0);
      i_rst = 1'b0;
      @(posedge i_clk); #1;

      // All-zero syndromes, GF(2^6)
      for (int i = 0; i < NS; i++) sv[i] = 0;
      send(0, 0, 1);
      wait_idle();
      chk("zero_sigma_lit", bus.o_sigma, 1);
      chk("zero_deg_lit",   bus.o_deg, 0);
      chk("zero_fail_lit",  bus.o_fail, 0);

      // Single error at alpha^5, GF(2^6): sigma = a^15 + a^20 x
      for (int j = 1; j <= NS; j++) sv[j-1] = gpow(0, 5 * j);
      send(0, 0, 1);
      wait_idle();
      chk("single_sigma_lit", bus.o_sigma, 64'h0F028);
      chk("single_deg_lit",   bus.o_deg, 1);
      chk("single_fail_lit",  bus.o_fail, 0);

      // S1=S2=1, rest 0, GF(2^6): sigma = 1+x+x^2 while L=1 -> failure
      for (int i = 0; i < NS; i++) sv[i] = (i < 2) ? 1 : 0;
      send(0, 0, 1);
      wait_idle();
      chk("failcase_sigma_lit", bus.o_sigma, 64'h100401);
      chk("failcase_deg_lit",   bus.o_deg, 1);
      chk("failcase_fail_lit",  bus.o_fail, 1);

      // Bits above m=6 only: treated as all-zero syndromes
      for (int i = 0; i < NS; i++) sv[i] = 32'h3C0;
      send(0, 0, 1);
      wait_idle();
      chk("upper_ignored_sigma", bus.o_sigma, 1);

      // Directed GF(2^8) vectors
      for (int ne = 1; ne <= T; ne++) begin
         gen_err(1, ne);
         send(1, 0, 1);
      end
      wait_idle();

      // i_start while busy is ignored
      gen_err(2, 3);
      send(2, 0, 1);
      for (int i = 0; i < NS; i++) sv[i] = $urandom_range(1023, 1);
      for (int i = 0; i < NS; i++) bus.i_synd[i*M +: M] = sv[i][M-1:0];
      bus.i_code  = 2'b01;
      bus.i_start = 1'b1;
      chk("busy_not_ready", bus.o_ready, 0);
      @(posedge i_clk); #1;
      bus.i_start = 1'b0;
      wait_idle();

      // Reserved field code is ignored
      bus.i_code  = 2'b11;
      bus.i_start = 1'b1;
      @(posedge i_clk); #1;
      bus.i_start = 1'b0;
      for (int i = 0; i < NS; i++) begin
         chk("reserved_ready", bus.o_ready, 1);
         @(posedge i_clk); #1;
      end

      // Reset at ITER cycle 2 aborts, and wins over a simultaneous start
      gen_err(0, 2);
      send(0, 0, 0);
      @(posedge i_clk); #1;
      chk("abort_busy", bus.o_ready, 0);
      i_rst       = 1'b1;
      bus.i_code  = 2'b00;
      bus.i_start = 1'b1;
      @(posedge i_clk); #1;
      i_rst       = 1'b0;
      bus.i_start = 1'b0;
      chk("abort_ready", bus.o_ready, 1);
      chk("abort_valid", bus.o_valid, 0);
      chk("abort_sigma", bus.o_sigma, 0);
      repeat (NS) @(posedge i_clk);
      #1;

      // GF(2^6) error patterns
      for (int v = 0; v < 12; v++) begin
         gen_err(0, 1 + (v % T));
         send(0, (v % 3) != 0, 1);
      end
      wait_idle();

      // GF(2^10) random 1..4 error patterns, mostly back-to-back
      for (int v = 0; v < 200; v++) begin
         gen_err(2, 1 + (v % T));
         send(2, (v % 5) != 0, 1);
      end
      wait_idle();

      // GF(2^10) arbitrary syndromes
      for (int v = 0; v < 20; v++) begin
         for (int i = 0; i < NS; i++) sv[i] = $urandom_range(1023, 0);
         send(2, (v % 2) != 0, 1);
      end
      wait_idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
